stopwatch_core: RTL and testbench
=================================

Name: stopwatch_core

Overview:
Time-base producer for the stopwatch display path. It counts centiseconds, seconds and minutes under run/stop/clear control. It drives the msec/sec values that the FND display controller consumes. It sits between the button front end, which supplies debounced single-cycle pulses, and the display controller.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
TICK_HZ, 100, count rate of o_msec in Hz; DIV = CLK_FREQ/TICK_HZ, must be an integer >= 2
MSEC_MAX, 99, terminal value of o_msec before carry
SEC_MAX, 59, terminal value of o_sec before carry
MIN_MAX, 59, terminal value of o_min before wrap

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
i_run_stop  input  1  one-cycle pulse; toggles run/stop
i_clear  input  1  one-cycle pulse; zeroes time while stopped
o_msec  output  7  centiseconds, 0..MSEC_MAX
o_sec  output  6  seconds, 0..SEC_MAX
o_min  output  6  minutes, 0..MIN_MAX
o_running  output  1  1 while the FSM is in RUN

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset: state=STOP, prescaler=0, o_msec=0, o_sec=0, o_min=0, o_running=0. rst overrides every other input in the same cycle, including mid-RUN.
- All outputs are registered. o_running is decoded directly from the state register.

FSM states: STOP, RUN, CLEAR.
- STOP, with i_clear=1 -> CLEAR. i_clear has priority over i_run_stop when both are asserted in the same cycle.
- STOP, with i_run_stop=1 and i_clear=0 -> RUN.
- RUN, with i_run_stop=1 -> STOP. i_clear is ignored in RUN, whether or not i_run_stop is also asserted.
- CLEAR -> STOP unconditionally after one cycle. Pulses arriving while in CLEAR are ignored.

Prescaler:
- Counts 0..DIV-1, and only while the state is RUN.
- Holds its value in STOP, so elapsed time is not lost across pause/resume.
- Forced to 0 in CLEAR.
- Tick: on the edge where the state is RUN and prescaler==DIV-1, the prescaler goes to 0 and the time counters advance by one in that same edge.
- From prescaler=0, the first o_msec increment occurs DIV clocks after the state becomes RUN.
- The edge that leaves RUN (the i_run_stop pulse) still performs a pending tick if prescaler==DIV-1 on that edge.

Counters:
- o_msec increments on each tick.
- At o_msec==MSEC_MAX with a tick: o_msec goes to 0 and o_sec increments.
- At o_sec==SEC_MAX with a carry: o_sec goes to 0 and o_min increments.
- At o_min==MIN_MAX with a carry: o_min goes to 0, so the full count wraps to 00:00.00. There is no overflow flag.
- All carries settle in the same edge; no intermediate value is ever visible.

CLEAR state:
- The edge entering CLEAR does not change the counters.
- During the CLEAR cycle, o_msec, o_sec and o_min are loaded with 0 and the prescaler is cleared. Zeros are visible in the cycle that returns to STOP.

Widths: comparisons are done at full port width. Values above the MAX parameters never occur.

Test Plan:
- Reset and idle: pulse rst for 2 clocks, then idle for 1000 clocks -> all outputs 0 and o_running=0 throughout.
- Tick timing (CLK_FREQ=1000, TICK_HZ=100, DIV=10): i_run_stop pulse at cycle 0 -> o_running=1 at cycle 1, o_msec=1 after cycle 11, o_msec=5 after cycle 51.
- Carry chain: run until min=0, sec=59, msec=99, then apply one more tick -> 01:00.00 in a single edge. Run on to 59:59.99 plus one tick -> 00:00.00.
- Pause/resume: stop when prescaler=7 and o_msec=3; wait 100 clocks -> values frozen. Resume -> o_msec=4 exactly 3 clocks after entering RUN.
- Clear rules: i_clear in RUN -> ignored, counting continues. i_clear and i_run_stop together in STOP with 00:12.34 -> CLEAR, then STOP with 00:00.00, o_running never asserts.
- Reset mid-run: assert rst during RUN at 00:05.67 -> next edge gives all zeros, state STOP, o_running=0.

Source files
------------

// File: rtl/stopwatch_core_if.sv
// Stopwatch control/time bus: debounced button pulses in, time-of-day digits
// and run flag out toward the FND display controller.
interface stopwatch_core_if;
   logic       i_run_stop;
   logic       i_clear;
   logic [6:0] o_msec;
   logic [5:0] o_sec;
   logic [5:0] o_min;
   logic       o_running;

   // Button front end / display side.
   modport master (
      output i_run_stop,
      output i_clear,
      input  o_msec,
      input  o_sec,
      input  o_min,
      input  o_running
   );

   // Stopwatch core side.
   modport slave (
      input  i_run_stop,
      input  i_clear,
      output o_msec,
      output o_sec,
      output o_min,
      output o_running
   );
endinterface

// File: rtl/stopwatch_core.sv
// Stopwatch time base: STOP/RUN/CLEAR control, a clock prescaler producing a
// TICK_HZ tick, and a centisecond/second/minute counter chain with wrap.
module stopwatch_core #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int TICK_HZ  = 100,
   parameter int MSEC_MAX = 99,
   parameter int SEC_MAX  = 59,
   parameter int MIN_MAX  = 59
) (
   input  logic            clk,
   input  logic            rst,
   stopwatch_core_if.slave sw
);

   localparam int              DIV       = CLK_FREQ / TICK_HZ;
   localparam int              PW        = $clog2(DIV);
   localparam logic [PW-1:0]   PRE_LAST  = PW'(DIV - 1);
   localparam logic [6:0]      MSEC_LAST = 7'(MSEC_MAX);
   localparam logic [5:0]      SEC_LAST  = 6'(SEC_MAX);
   localparam logic [5:0]      MIN_LAST  = 6'(MIN_MAX);

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] pre_q,   pre_d;
   logic [6:0]    msec_q,  msec_d;
   logic [5:0]    sec_q,   sec_d;
   logic [5:0]    min_q,   min_d;
   logic          tick;

   // Control FSM: clear wins over run/stop in STOP; clear is ignored in RUN.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_STOP: begin
            if (sw.i_clear)
               state_d = ST_CLEAR;
            else if (sw.i_run_stop)
               state_d = ST_RUN;
         end
         ST_RUN: begin
            if (sw.i_run_stop)
               state_d = ST_STOP;
         end
         ST_CLEAR: state_d = ST_STOP;
         default:  state_d = ST_STOP;
      endcase
   end

   // Prescaler and counter chain; the tick is judged on the current state so
   // the edge that leaves RUN still completes a pending tick.
   always_comb begin
      tick   = (state_q == ST_RUN) && (pre_q == PRE_LAST);
      pre_d  = pre_q;
      msec_d = msec_q;
      sec_d  = sec_q;
      min_d  = min_q;
      if (state_q == ST_CLEAR) begin
         pre_d  = '0;
         msec_d = '0;
         sec_d  = '0;
         min_d  = '0;
      end else if (state_q == ST_RUN) begin
         if (tick) begin
            pre_d = '0;
            if (msec_q == MSEC_LAST) begin
               msec_d = '0;
               if (sec_q == SEC_LAST) begin
                  sec_d = '0;
                  min_d = (min_q == MIN_LAST) ? 6'd0 : min_q + 6'd1;
               end else begin
                  sec_d = sec_q + 6'd1;
               end
            end else begin
               msec_d = msec_q + 7'd1;
            end
         end else begin
            pre_d = pre_q + 1'b1;
         end
      end
   end

   // State and counter registers; reset returns everything to a stopped 00:00.00.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_STOP;
         pre_q   <= '0;
         msec_q  <= '0;
         sec_q   <= '0;
         min_q   <= '0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         msec_q  <= msec_d;
         sec_q   <= sec_d;
         min_q   <= min_d;
      end
   end

   assign sw.o_msec    = msec_q;
   assign sw.o_sec     = sec_q;
   assign sw.o_min     = min_q;
   assign sw.o_running = (state_q == ST_RUN);

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: directed scenarios plus random button/reset
// traffic, every cycle compared with a model that keeps elapsed time as a
// single tick count and derives the digits arithmetically.
module tb_stopwatch_core;

   localparam int CLK_FREQ = 1000;
   localparam int TICK_HZ  = 100;
   localparam int DIV      = CLK_FREQ / TICK_HZ;
   localparam int MS       = 9;
   localparam int SS       = 59;
   localparam int MM       = 2;
   localparam int FULL     = (MS + 1) * (SS + 1) * (MM + 1);

   localparam int M_STOP  = 0;
   localparam int M_RUN   = 1;
   localparam int M_CLEAR = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   stopwatch_core_if sw_if ();

   stopwatch_core #(
      .CLK_FREQ (CLK_FREQ),
      .TICK_HZ  (TICK_HZ),
      .MSEC_MAX (MS),
      .SEC_MAX  (SS),
      .MIN_MAX  (MM)
   ) dut (
      .clk (clk),
      .rst (rst),
      .sw  (sw_if)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference: mode, prescaler phase, and total elapsed ticks modulo FULL.
   int m_mode = M_STOP;
   int m_pre  = 0;
   int m_t    = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge(input bit r, input bit rs, input bit clr);
      if (r) begin
         m_mode = M_STOP;
         m_pre  = 0;
         m_t    = 0;
      end else begin
         case (m_mode)
            M_RUN: begin
               if (m_pre == DIV - 1) begin
                  m_pre = 0;
                  m_t   = (m_t + 1) % FULL;
               end else begin
                  m_pre = m_pre + 1;
               end
               if (rs) m_mode = M_STOP;
            end
            M_CLEAR: begin
               m_pre  = 0;
               m_t    = 0;
               m_mode = M_STOP;
            end
            default: begin
               if (clr)     m_mode = M_CLEAR;
               else if (rs) m_mode = M_RUN;
            end
         endcase
      end
   endtask

   function automatic int dut_time();
      return int'(sw_if.o_msec) + (MS + 1) * (int'(sw_if.o_sec) + (SS + 1) * int'(sw_if.o_min));
   endfunction

   task automatic check_outputs(input string tag);
      chk({tag, ".msec"}, int'(sw_if.o_msec),    m_t % (MS + 1));
      chk({tag, ".sec"},  int'(sw_if.o_sec),     (m_t / (MS + 1)) % (SS + 1));
      chk({tag, ".min"},  int'(sw_if.o_min),     m_t / ((MS + 1) * (SS + 1)));
      chk({tag, ".run"},  int'(sw_if.o_running), (m_mode == M_RUN) ? 1 : 0);
   endtask

   // One clock: inputs applied after the falling edge, outputs checked at the next one.
   task automatic cyc(input bit r, input bit rs, input bit clr, input string tag);
      rst              = r;
      sw_if.i_run_stop = rs;
      sw_if.i_clear    = clr;
      @(posedge clk);
      model_edge(r, rs, clr);
      @(negedge clk);
      rst              = 1'b0;
      sw_if.i_run_stop = 1'b0;
      sw_if.i_clear    = 1'b0;
      check_outputs(tag);
   endtask

   task automatic run_to(input int tgt_t, input int tgt_pre, input string tag);
      int n = 0;
      while (!(m_t == tgt_t && m_pre == tgt_pre) && n < 2 * FULL * DIV) begin
         cyc(1'b0, 1'b0, 1'b0, tag);
         n++;
      end
      chk({tag, ".at"}, dut_time(), tgt_t);
   endtask

   initial begin
      bit r, rs, clr;
      rst              = 1'b1;
      sw_if.i_run_stop = 1'b0;
      sw_if.i_clear    = 1'b0;
      @(negedge clk);

      // Reset and long idle.
      cyc(1'b1, 1'b0, 1'b0, "rst");
      cyc(1'b1, 1'b0, 1'b0, "rst");
      chk("rst.msec0", int'(sw_if.o_msec), 0);
      chk("rst.running0", int'(sw_if.o_running), 0);
      repeat (1000) cyc(1'b0, 1'b0, 1'b0, "idle");

      // Tick timing: first increment DIV clocks after entering RUN.
      cyc(1'b0, 1'b1, 1'b0, "start");
      chk("start.running", int'(sw_if.o_running), 1);
      repeat (DIV - 1) cyc(1'b0, 1'b0, 1'b0, "tick");
      chk("tick.before", int'(sw_if.o_msec), 0);
      cyc(1'b0, 1'b0, 1'b0, "tick");
      chk("tick.first", int'(sw_if.o_msec), 1);
      repeat (4 * DIV) cyc(1'b0, 1'b0, 1'b0, "tick");
      chk("tick.fifth", int'(sw_if.o_msec), 5);

      // Clear is ignored in RUN, alone or with run/stop.
      cyc(1'b0, 1'b0, 1'b1, "clr_in_run");
      chk("clr_in_run.running", int'(sw_if.o_running), 1);
      cyc(1'b0, 1'b1, 1'b1, "clr_rs_in_run");
      chk("clr_rs_in_run.running", int'(sw_if.o_running), 0);
      chk("clr_rs_in_run.msec", int'(sw_if.o_msec), 5);
      cyc(1'b0, 1'b0, 1'b1, "clr");
      cyc(1'b0, 1'b0, 1'b0, "clr_done");
      chk("clr_done.msec", int'(sw_if.o_msec), 0);

      // Pause with prescaler at 7, resume completes the tick 3 clocks later.
      cyc(1'b0, 1'b1, 1'b0, "p_start");
      run_to(3, 6, "p_run");
      cyc(1'b0, 1'b1, 1'b0, "p_stop");
      repeat (100) cyc(1'b0, 1'b0, 1'b0, "p_frozen");
      chk("p_frozen.msec", int'(sw_if.o_msec), 3);
      cyc(1'b0, 1'b1, 1'b0, "p_resume");
      repeat (2) cyc(1'b0, 1'b0, 1'b0, "p_wait");
      chk("p_wait.msec", int'(sw_if.o_msec), 3);
      cyc(1'b0, 1'b0, 1'b0, "p_tick");
      chk("p_tick.msec", int'(sw_if.o_msec), 4);

      // Clear and run/stop together in STOP: clear wins, no RUN cycle.
      run_to(123, 0, "c_run");
      cyc(1'b0, 1'b1, 1'b0, "c_stop");
      chk("c_stop.sec", int'(sw_if.o_sec), 12);
      cyc(1'b0, 1'b1, 1'b1, "c_both");
      chk("c_both.running", int'(sw_if.o_running), 0);
      chk("c_both.kept", dut_time(), 123);
      cyc(1'b0, 1'b0, 1'b0, "c_zero");
      chk("c_zero.time", dut_time(), 0);
      chk("c_zero.running", int'(sw_if.o_running), 0);

      // Reset in the middle of a run.
      cyc(1'b0, 1'b1, 1'b0, "r_start");
      run_to(57, 0, "r_run");
      cyc(1'b1, 1'b0, 1'b0, "r_rst");
      chk("r_rst.time", dut_time(), 0);
      chk("r_rst.running", int'(sw_if.o_running), 0);

      // Carry chain: 00:59.9 -> 01:00.0, and full wrap to 00:00.0.
      cyc(1'b0, 1'b1, 1'b0, "k_start");
      run_to(SS * (MS + 1) + MS, DIV - 1, "k_run");
      cyc(1'b0, 1'b0, 1'b0, "k_carry");
      chk("k_carry.min", int'(sw_if.o_min), 1);
      chk("k_carry.sec", int'(sw_if.o_sec), 0);
      chk("k_carry.msec", int'(sw_if.o_msec), 0);
      run_to(FULL - 1, DIV - 1, "w_run");
      cyc(1'b0, 1'b0, 1'b0, "w_wrap");
      chk("w_wrap.time", dut_time(), 0);
      chk("w_wrap.running", int'(sw_if.o_running), 1);

      // Random button and reset traffic.
      repeat (4000) begin
         r   = ($urandom_range(0, 299) == 0);
         rs  = ($urandom_range(0, 24) == 0);
         clr = ($urandom_range(0, 29) == 0);
         cyc(r, rs, clr, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
